// File: rtl/rptr_status.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module   : rptr_status                                                    |
// | Purpose  : Read-domain pointer, Gray export, empty/almost-empty, level     |
// |            and sticky underflow flag for the dual-clock FIFO.              |
// | Revision : 1.0                                                             |
// +---------------------------------------------------------------------------+
module rptr_status #(
  parameter int ADDR_WIDTH    = 3,
  parameter int AEMPTY_THRESH = 1
) (
  input  logic                  rclk,
  input  logic                  rst_n,
  input  logic                  rinc,
  input  logic [ADDR_WIDTH:0]   wptr_sync,
  input  logic                  uf_clr,
  output logic                  rd_ok,
  output logic [ADDR_WIDTH-1:0] raddr,
  output logic [ADDR_WIDTH:0]   rptr,
  output logic                  empty,
  output logic                  aempty,
  output logic [ADDR_WIDTH:0]   rlevel,
  output logic                  underflow
);

  localparam int PTR_W = ADDR_WIDTH + 1;
  localparam logic [PTR_W-1:0] c_aempty_thresh = PTR_W'(AEMPTY_THRESH);

  logic [PTR_W-1:0] r_rbin;
  logic [PTR_W-1:0] r_rptr;
  logic             r_empty;
  logic             r_aempty;
  logic [PTR_W-1:0] r_rlevel;
  logic             r_underflow;

  logic             w_rd_ok;
  logic [PTR_W-1:0] w_rbin_next;
  logic [PTR_W-1:0] w_rgray_next;
  logic [PTR_W-1:0] w_wbin;
  logic [PTR_W-1:0] w_level_next;

  assign w_rd_ok      = rinc & ~r_empty;
  assign w_rbin_next  = r_rbin + {{ADDR_WIDTH{1'b0}}, w_rd_ok};
  assign w_rgray_next = (w_rbin_next >> 1) ^ w_rbin_next;
  assign w_level_next = w_wbin - w_rbin_next;

  // Gray to binary: each bit is the XOR of itself and every higher Gray bit.
  always_comb begin
    w_wbin = '0;
    w_wbin[PTR_W-1] = wptr_sync[PTR_W-1];
    for (int i = PTR_W - 2; i >= 0; i--) begin
      w_wbin[i] = w_wbin[i+1] ^ wptr_sync[i];
    end
  end

  always_ff @(posedge rclk or negedge rst_n) begin
    if (!rst_n) begin
      r_rbin   <= '0;
      r_rptr   <= '0;
      r_empty  <= 1'b1;
      r_aempty <= 1'b1;
      r_rlevel <= '0;
    end else begin
      r_rbin   <= w_rbin_next;
      r_rptr   <= w_rgray_next;
      r_empty  <= (w_rgray_next == wptr_sync);
      r_aempty <= (w_level_next <= c_aempty_thresh);
      r_rlevel <= w_level_next;
    end
  end

  // Set has priority over clear so a fresh underflow is never lost.
  always_ff @(posedge rclk or negedge rst_n) begin
    if (!rst_n) begin
      r_underflow <= 1'b0;
    end else if (rinc && r_empty) begin
      r_underflow <= 1'b1;
    end else if (uf_clr) begin
      r_underflow <= 1'b0;
    end
  end

  assign rd_ok     = w_rd_ok;
  assign raddr     = r_rbin[ADDR_WIDTH-1:0];
  assign rptr      = r_rptr;
  assign empty     = r_empty;
  assign aempty    = r_aempty;
  assign rlevel    = r_rlevel;
  assign underflow = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_rptr_status.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module   : tb_rptr_status                                                 |
// | Purpose  : Self-checking bench for rptr_status (ADDR_WIDTH=3, thresh=2).   |
// | Revision : 1.0                                                             |
// +---------------------------------------------------------------------------+
module tb_rptr_status;

  typedef struct packed {
    logic [2:0] raddr;
    logic [3:0] rptr;
    logic       empty;
    logic       aempty;
    logic [3:0] rlevel;
    logic       uf;
  } exp_t;

  typedef struct packed {
    logic       rinc;
    logic       ufc;
    logic [3:0] wg;
    logic       rdok;
    exp_t       e;
  } vec_t;

  logic       rclk;
  logic       rst_n;
  logic       rinc;
  logic [3:0] wptr_sync;
  logic       uf_clr;
  logic       rd_ok;
  logic [2:0] raddr;
  logic [3:0] rptr;
  logic       empty;
  logic       aempty;
  logic [3:0] rlevel;
  logic       underflow;

  int   checks = 0;
  int   errors = 0;
  vec_t vt[$];
  exp_t sb[$];

  rptr_status #(.ADDR_WIDTH(3), .AEMPTY_THRESH(2)) dut (
    .rclk(rclk), .rst_n(rst_n), .rinc(rinc), .wptr_sync(wptr_sync),
    .uf_clr(uf_clr), .rd_ok(rd_ok), .raddr(raddr), .rptr(rptr),
    .empty(empty), .aempty(aempty), .rlevel(rlevel), .underflow(underflow)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  function automatic logic [3:0] gray(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic chk_reset(input int idx);
    chk("rst_rptr", idx, 32'(rptr), 32'h0);
    chk("rst_raddr", idx, 32'(raddr), 32'h0);
    chk("rst_empty", idx, 32'(empty), 32'h1);
    chk("rst_aempty", idx, 32'(aempty), 32'h1);
    chk("rst_rlevel", idx, 32'(rlevel), 32'h0);
    chk("rst_underflow", idx, 32'(underflow), 32'h0);
    chk("rst_rd_ok", idx, 32'(rd_ok), 32'h0);
  endtask

  task automatic add(input logic ri, input logic uc, input logic [3:0] wg, input logic rd,
                     input logic [2:0] ra, input logic [3:0] rp, input logic em,
                     input logic ae, input logic [3:0] lv, input logic uf);
    vec_t v;
    v.rinc = ri; v.ufc = uc; v.wg = wg; v.rdok = rd;
    v.e.raddr = ra; v.e.rptr = rp; v.e.empty = em; v.e.aempty = ae;
    v.e.rlevel = lv; v.e.uf = uf;
    vt.push_back(v);
  endtask

  task automatic step(input logic ri, input logic uc, input logic [3:0] wg,
                      input logic erd, input exp_t e, input int idx);
    exp_t got;
    @(negedge rclk);
    rinc = ri; uf_clr = uc; wptr_sync = wg;
    #1;
    chk("rd_ok", idx, 32'(rd_ok), 32'(erd));
    sb.push_back(e);
    @(posedge rclk);
    #1;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard step %0d: got empty queue expected entry", idx);
    end else begin
      got = sb.pop_front();
      chk("raddr", idx, 32'(raddr), 32'(got.raddr));
      chk("rptr", idx, 32'(rptr), 32'(got.rptr));
      chk("empty", idx, 32'(empty), 32'(got.empty));
      chk("aempty", idx, 32'(aempty), 32'(got.aempty));
      chk("rlevel", idx, 32'(rlevel), 32'(got.rlevel));
      chk("underflow", idx, 32'(underflow), 32'(got.uf));
    end
  endtask

  initial begin
    logic [3:0] m_rbin, m_wbin, m_rbin_n, m_lvl;
    logic       m_empty, m_uf, m_rd, ri, uc;
    exp_t       e;

    rst_n = 1'b1; rinc = 1'b0; uf_clr = 1'b0; wptr_sync = 4'h0;
    #1;
    rst_n = 1'b0;
    rinc = 1'($urandom); uf_clr = 1'($urandom); wptr_sync = 4'($urandom);
    #2;
    rinc = 1'b0;
    #0;
    chk_reset(0);
    rinc = 1'b0; uf_clr = 1'b0; wptr_sync = 4'h0;
    repeat (2) @(posedge rclk);
    @(negedge rclk);
    rst_n = 1'b1;

    //  rinc uf   wg       rdok raddr rptr     em ae lvl uf
    add(0, 0, 4'b0001, 0, 3'd0, 4'b0000, 0, 1, 4'd1, 0);   // fill
    add(0, 0, 4'b0011, 0, 3'd0, 4'b0000, 0, 1, 4'd2, 0);
    add(0, 0, 4'b0010, 0, 3'd0, 4'b0000, 0, 0, 4'd3, 0);
    add(0, 0, 4'b1100, 0, 3'd0, 4'b0000, 0, 0, 4'd8, 0);
    add(1, 0, 4'b1100, 1, 3'd1, 4'b0001, 0, 0, 4'd7, 0);   // full drain
    add(1, 0, 4'b1100, 1, 3'd2, 4'b0011, 0, 0, 4'd6, 0);
    add(1, 0, 4'b1100, 1, 3'd3, 4'b0010, 0, 0, 4'd5, 0);
    add(1, 0, 4'b1100, 1, 3'd4, 4'b0110, 0, 0, 4'd4, 0);
    add(1, 0, 4'b1100, 1, 3'd5, 4'b0111, 0, 0, 4'd3, 0);
    add(1, 0, 4'b1100, 1, 3'd6, 4'b0101, 0, 1, 4'd2, 0);
    add(1, 0, 4'b1100, 1, 3'd7, 4'b0100, 0, 1, 4'd1, 0);
    add(1, 0, 4'b1100, 1, 3'd0, 4'b1100, 1, 1, 4'd0, 0);
    add(1, 0, 4'b1100, 0, 3'd0, 4'b1100, 1, 1, 4'd0, 1);   // underflow
    add(0, 0, 4'b1100, 0, 3'd0, 4'b1100, 1, 1, 4'd0, 1);
    add(1, 1, 4'b1100, 0, 3'd0, 4'b1100, 1, 1, 4'd0, 1);
    add(0, 1, 4'b1100, 0, 3'd0, 4'b1100, 1, 1, 4'd0, 0);
    add(0, 0, 4'b1001, 0, 3'd0, 4'b1100, 0, 0, 4'd6, 0);   // advance to rbin=14
    add(1, 0, 4'b1001, 1, 3'd1, 4'b1101, 0, 0, 4'd5, 0);
    add(1, 0, 4'b1001, 1, 3'd2, 4'b1111, 0, 0, 4'd4, 0);
    add(1, 0, 4'b1001, 1, 3'd3, 4'b1110, 0, 0, 4'd3, 0);
    add(1, 0, 4'b1001, 1, 3'd4, 4'b1010, 0, 1, 4'd2, 0);
    add(1, 0, 4'b1001, 1, 3'd5, 4'b1011, 0, 1, 4'd1, 0);
    add(1, 0, 4'b1001, 1, 3'd6, 4'b1001, 1, 1, 4'd0, 0);
    add(0, 0, 4'b0001, 0, 3'd6, 4'b1001, 0, 0, 4'd3, 0);   // pointer wrap
    add(1, 0, 4'b0001, 1, 3'd7, 4'b1000, 0, 1, 4'd2, 0);
    add(1, 0, 4'b0001, 1, 3'd0, 4'b0000, 0, 1, 4'd1, 0);
    add(1, 0, 4'b0001, 1, 3'd1, 4'b0001, 1, 1, 4'd0, 0);
    add(0, 0, 4'b0010, 0, 3'd1, 4'b0001, 0, 1, 4'd2, 0);   // simultaneous
    add(1, 0, 4'b0110, 1, 3'd2, 4'b0011, 0, 1, 4'd2, 0);
    add(1, 0, 4'b0111, 1, 3'd3, 4'b0010, 0, 1, 4'd2, 0);
    add(1, 0, 4'b1100, 1, 3'd4, 4'b0110, 0, 0, 4'd4, 0);

    foreach (vt[i]) step(vt[i].rinc, vt[i].ufc, vt[i].wg, vt[i].rdok, vt[i].e, i + 1);

    // Reset mid-drain: takes effect between clock edges.
    @(negedge rclk);
    rinc = 1'b1;
    #1;
    chk("pre_rst_rd_ok", 100, 32'(rd_ok), 32'h1);
    rst_n = 1'b0;
    #1;
    chk_reset(100);
    repeat (2) @(posedge rclk);
    #1;
    chk_reset(101);
    @(negedge rclk);
    rinc = 1'b0; wptr_sync = 4'h0;
    rst_n = 1'b1;

    // Random legal traffic against a behavioural model.
    m_rbin = 4'd0; m_wbin = 4'd0; m_empty = 1'b1; m_uf = 1'b0;
    for (int n = 0; n < 300; n++) begin
      ri = 1'($urandom_range(0, 2) != 0);
      uc = 1'($urandom_range(0, 5) == 0);
      if ((4'(m_wbin - m_rbin) < 4'd8) && ($urandom_range(0, 1) == 1)) m_wbin = m_wbin + 4'd1;
      m_rd     = ri & ~m_empty;
      m_rbin_n = m_rbin + 4'(m_rd);
      m_lvl    = m_wbin - m_rbin_n;
      m_uf     = (ri & m_empty) ? 1'b1 : (uc ? 1'b0 : m_uf);
      e.raddr  = m_rbin_n[2:0];
      e.rptr   = gray(m_rbin_n);
      e.empty  = (m_lvl == 4'd0);
      e.aempty = (m_lvl <= 4'd2);
      e.rlevel = m_lvl;
      e.uf     = m_uf;
      step(ri, uc, gray(m_wbin), m_rd, e, 200 + n);
      m_rbin  = m_rbin_n;
      m_empty = e.empty;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
